// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame layout, FSM states and
// the frame acceptance check.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int START          = 0;
  localparam int PARITY         = 9;
  localparam int STOP           = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  // Start low, odd parity over data[7:0] plus the parity bit, stop high.
  function automatic logic frame_good(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[START] == 1'b0) && (^f[PARITY:1]) && f[STOP];
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// 2-FF synchronizer plus hysteresis filter for the raw PS/2 clock pin.
// Emits the filtered level and a one-cycle pulse on its 1->0 transition.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_bus,
  input  logic nreset,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  all_lo;
  logic                  all_hi;

  assign all_lo = ~|hist;
  assign all_hi = &hist;

  // Everything presets high so leaving reset on an idle bus is edge-free.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      hist <= {hist[FILTER_LEN-2:0], sync[1]};
      fall <= level & all_lo;
      if (all_lo)      level <= 1'b0;
      else if (all_hi) level <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// Receive-only PS/2 device-to-host deserializer: captures 11-bit frames on
// filtered clock falls and strobes out good scan-code bytes or an error.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_bus,
  input  logic       nreset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       error
);

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);

  logic                      clk_lvl;
  logic                      clk_fall;
  logic                      fall;
  logic [1:0]                dat_sync;
  logic                      dat;
  ps2_state_e                state;
  logic [3:0]                bit_cnt;
  logic [19:0]               to_cnt;
  logic [PS2_FRAME_BITS-2:0] frame;
  logic [PS2_FRAME_BITS-1:0] frame_n;
  logic                      last_bit;
  logic                      timeout;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_bus (clk_bus),
    .nreset  (nreset),
    .raw     (ps2_clk),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  assign fall     = clk_fall & ~clk_lvl;
  assign dat      = dat_sync[1];
  assign frame_n  = {dat, frame};
  assign last_bit = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
  assign timeout  = (state == RECV) && (to_cnt == TO_LAST);

  // The frame is judged on the fall that captures the stop bit, so the
  // strobe and the new byte are both visible during the single CHECK cycle.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      dat_sync <= '1;
      state    <= IDLE;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      frame    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      dat_sync <= {dat_sync[0], ps2_dat};
      valid    <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !dat) begin
            frame   <= frame_n[PS2_FRAME_BITS-1:1];
            bit_cnt <= 4'd1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (timeout) begin
            state   <= IDLE;
            error   <= 1'b1;
            to_cnt  <= '0;
            bit_cnt <= '0;
          end else if (fall) begin
            to_cnt  <= '0;
            frame   <= frame_n[PS2_FRAME_BITS-1:1];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              state <= CHECK;
              if (frame_good(frame_n)) begin
                data  <= frame_n[8:1];
                valid <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end
          end else begin
            to_cnt <= to_cnt + 20'd1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= '0;
          to_cnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
Receive-only PS/2 device-to-host deserializer feeding keyboard_wb.
- Synchronizes and de-glitches the raw PS2_CLK/PS2_DAT pins.
- Captures 11-bit frames on filtered clock falling edges and checks start, odd parity and stop bits.
- Presents each good scan-code byte with a one-cycle valid strobe.
- Never drives the PS/2 lines; host-to-device (LED/reset commands) is out of scope.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized PS2_CLK samples needed to change the filtered clock level (range 2..16)
TIMEOUT, 50000, clk_bus cycles with no filtered falling edge before a partial frame is aborted (must be < 2^20)

Ports:
clk_bus  in  1  system clock; all logic on rising edge
nreset  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_dat  in  1  raw PS/2 data pin, asynchronous
data  out  8  last good received byte
valid  out  1  one-cycle strobe: new byte on data
error  out  1  one-cycle strobe: frame rejected (bad start, bad parity, bad stop, or timeout)

Behaviour:
- Clock and reset: one clock, clk_bus. Reset nreset is asynchronous assert, active-low. Deassertion is used directly; no internal reset synchronizer is required.
- Reset state:
  - data=0, valid=0, error=0.
  - FSM=IDLE, bit counter=0, timeout counter=0.
  - Synchronizers, filter history and filtered clock all preset to 1 (bus idle high), so release of reset never creates a false edge.
- Synchronization: 2-FF synchronizer on each pin.
- Clock filter:
  - FILTER_LEN-deep shift history of the synchronized clock.
  - Filtered clock goes 0 only when all entries are 0 and goes 1 only when all entries are 1; otherwise it holds.
  - A pulse shorter than FILTER_LEN cycles never changes the filtered level.
- Edge: fall = one-cycle pulse when the filtered clock transitions 1->0. Data is sampled from the synchronized ps2_dat in that same cycle.
- FSM:
  - IDLE: on fall with dat=0, store the start bit, set the bit counter to 1 and go to RECV. On fall with dat=1, stay in IDLE with no strobe (line noise).
  - RECV: each fall shifts dat into the 11-bit frame register LSB-first and increments the counter. When the 11th bit (stop) is captured, go to CHECK.
  - CHECK (exactly one cycle):
    - Good frame when start==0, XOR of data[7:0] and parity == 1, and stop==1.
    - Good frame: load data and pulse valid.
    - Otherwise: pulse error and leave data unchanged.
    - Return to IDLE in both cases.
- Latency: valid/error is asserted in the cycle after the fall that captured the stop bit and lasts exactly 1 cycle. Pin-to-valid latency is 2 (sync) + FILTER_LEN + 2 cycles from the stop-bit clock falling at the pin.
- Timeout:
  - The counter clears on every fall and while in IDLE, and increments in RECV.
  - When it reaches TIMEOUT in RECV: go to IDLE, pulse error for 1 cycle, clear the counter.
  - A fall in the same cycle as the timeout is ignored; the next frame must start with a fresh start bit.
- Back-to-back frames: CHECK takes 1 cycle. A fall arriving while in CHECK cannot occur (PS/2 bit period is at least 60 us), so no queueing is provided and data is overwritten by each good frame.
- Consumer rule: keyboard_wb must sample data in the cycle valid is high; data stays stable until the next good frame.
- valid and error are never asserted in the same cycle.
- Reset mid-frame: partial frame discarded, no strobe.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, RECV, CHECK).
  - PS2_FRAME_BITS=11.
  - Bit-position constants START=0, PARITY=9, STOP=10.
- Sub-module ps2_filter: 2-FF synchronizer plus FILTER_LEN hysteresis filter. Outputs are the filtered level and the fall pulse. It is instantiated once for the clock; data uses only the 2-FF synchronizer inside ps2_rx.

Test Plan:
1. Frame for 0x1C (start 0, bits LSB-first, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> one valid pulse, data=0x1C, error stays 0.
2. Same frame with parity flipped to 1 -> one error pulse, no valid, data keeps the previous value 0x1C.
3. 3-cycle low glitch on ps2_clk (FILTER_LEN=8) in the middle of a 0x5A frame -> glitch ignored; valid with data=0x5A.
4. 4 bits of a frame then line held high for TIMEOUT+10 cycles -> error pulse TIMEOUT cycles after the last fall; a following 0x12 frame gives valid, data=0x12.
5. Back-to-back E0, F0, 75 frames with a 1-bit gap -> three valid pulses carrying 0xE0, 0xF0, 0x75 in order.
6. nreset asserted after bit 6 of a frame, released, then full 0x29 frame -> no strobe for the aborted frame, outputs 0 during reset, then valid with data=0x29.
